// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 key-to-hex source.
//               Holds the scan-code decoder state encoding and the PS/2
//               protocol byte values and frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Scan-code decoder states: plain, after F0, after E0, after E0 F0.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver. Synchronises the raw PS/2 clock and
//               data, detects falling clock edges, shifts in 11-bit frames
//               LSB first and checks start/odd-parity/stop.
//               Optional watchdog enabled by defining PS2_TIMEOUT_EN.
// Ports       : clk, clrn (async active-low reset)
//               ps2_clk, ps2_data   raw connector inputs
//               rx_byte             received data byte
//               byte_vld            1-cycle pulse, rx_byte valid
//               frame_err           1-cycle pulse on rejected/aborted frame
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bitcnt;
    logic [9:0]             r_shift;
    logic [7:0]             r_byte;
    logic                   r_vld;
    logic                   r_err;

    logic                   w_clk_cur;
    logic                   w_data;
    logic                   w_fall;
    logic                   w_last;
    logic [10:0]            w_frame;
    logic                   w_frame_ok;
    logic                   w_timeout;

    // Synchronisers idle at 1 so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_cur;
        end
    end

    assign w_clk_cur = r_clk_sync[SYNC_STAGES-1];
    assign w_data    = r_data_sync[SYNC_STAGES-1];
    assign w_fall    = r_clk_prev & ~w_clk_cur;

    // The shift register only holds the first ten bits; the eleventh (stop)
    // bit is taken straight from the synchroniser on the final edge.
    assign w_frame    = {w_data, r_shift};
    assign w_last     = (r_bitcnt == 4'(PS2_FRAME_BITS - 1));
    assign w_frame_ok = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];

`ifdef PS2_TIMEOUT_EN
    localparam int                c_wdog_w    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);

    logic [c_wdog_w-1:0] r_wdog;

    assign w_timeout = (r_bitcnt != 4'd0) && (r_wdog == c_wdog_last);

    // Counts idle cycles inside a partially received frame.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wdog <= '0;
        end else if (w_fall || (r_bitcnt == 4'd0) || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bitcnt <= 4'd0;
            r_shift  <= '0;
            r_byte   <= 8'd0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            if (w_fall) begin
                if (w_last) begin
                    r_bitcnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_vld  <= 1'b1;
                        r_byte <= w_frame[8:1];
                    end else begin
                        r_err  <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_shift  <= w_frame[10:1];
                end
            end else if (w_timeout) begin
                r_bitcnt <= 4'd0;
                r_err    <= 1'b1;
            end
        end
    end

    assign rx_byte   = r_byte;
    assign byte_vld  = r_vld;
    assign frame_err = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_hex_src.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_hex_src
// Description : PS/2 keyboard source for the board's 7-segment hex decoders.
//               Tracks make/break/extended scan codes, counts distinct key
//               presses and presents code and count as nibbles + enables.
//               Optional receiver watchdog enabled by defining PS2_TIMEOUT_EN.
// Ports       : clk, clrn (async active-low reset)
//               ps2_clk, ps2_data   raw PS/2 connector inputs
//               code_lo/code_hi     nibbles of last make code
//               code_en             1 while that key is held
//               cnt_lo/cnt_hi       nibbles of 8-bit press counter
//               cnt_en              press-count display enable (always on)
//               ext                 last make code was E0-prefixed
//               frame_err           1-cycle pulse on a rejected frame
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_hex_src
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] code_lo,
    output logic [3:0] code_hi,
    output logic       code_en,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       cnt_en,
    output logic       ext,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_vld;
    logic       w_press_ext;
    logic       w_new_press;
    logic       w_brk_hit;

    ps2_state_t r_state;
    logic [7:0] r_code;
    logic       r_ext;
    logic       r_code_en;
    logic [7:0] r_cnt;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (w_byte),
        .byte_vld (w_byte_vld),
        .frame_err(frame_err)
    );

    // A make code only counts when it is not a typematic repeat of the key
    // currently held (same byte and same E0 qualifier).
    assign w_press_ext = (r_state == EXT);
    assign w_new_press = !r_code_en || (w_byte != r_code) || (w_press_ext != r_ext);

    // A break only releases the held key if its E0 qualifier matches too.
    assign w_brk_hit   = (w_byte == r_code) &&
                         (((r_state == BRK) && !r_ext) || ((r_state == EXT_BRK) && r_ext));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_code    <= 8'd0;
            r_ext     <= 1'b0;
            r_code_en <= 1'b0;
            r_cnt     <= 8'd0;
        end else if (w_byte_vld) begin
            case (r_state)
                IDLE: begin
                    if (w_byte == PS2_EXT) begin
                        r_state <= EXT;
                    end else if (w_byte == PS2_BRK) begin
                        r_state <= BRK;
                    end else begin
                        if (w_new_press) r_cnt <= r_cnt + 8'd1;
                        r_code    <= w_byte;
                        r_ext     <= 1'b0;
                        r_code_en <= 1'b1;
                    end
                end
                EXT: begin
                    if (w_byte == PS2_BRK) begin
                        r_state <= EXT_BRK;
                    end else begin
                        if (w_new_press) r_cnt <= r_cnt + 8'd1;
                        r_code    <= w_byte;
                        r_ext     <= 1'b1;
                        r_code_en <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    if (w_brk_hit) r_code_en <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign code_lo = r_code[3:0];
    assign code_hi = r_code[7:4];
    assign code_en = r_code_en;
    assign ext     = r_ext;
    assign cnt_lo  = r_cnt[3:0];
    assign cnt_hi  = r_cnt[7:4];
    // The press count is always shown, including its leading zero digit.
    assign cnt_en  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_hex_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_hex_src
// Description : Self-checking bench for ps2_key_hex_src. Drives PS/2 frames
//               bit by bit and compares the displayed code/count against a
//               behavioural keyboard model. Timeout scenario runs only when
//               PS2_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_hex_src;

    localparam int c_tb_timeout = 200;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] code_lo;
    logic [3:0] code_hi;
    logic       code_en;
    logic [3:0] cnt_lo;
    logic [3:0] cnt_hi;
    logic       cnt_en;
    logic       ext;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;

    // Keyboard model: what the display should show.
    logic [7:0] m_code;
    logic       m_ext;
    logic       m_held;
    logic [7:0] m_cnt;
    logic       m_pend_ext;
    logic       m_pend_brk;

    logic [18:0] obs;
    assign obs = {code_hi, code_lo, code_en, ext, cnt_hi, cnt_lo, cnt_en};

    ps2_key_hex_src #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(c_tb_timeout)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code_lo  (code_lo),
        .code_hi  (code_hi),
        .code_en  (code_en),
        .cnt_lo   (cnt_lo),
        .cnt_hi   (cnt_hi),
        .cnt_en   (cnt_en),
        .ext      (ext),
        .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    function automatic logic [18:0] exp_vec();
        return {m_code, m_held, m_ext, m_cnt, 1'b1};
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad);
        logic par;
        par = (~^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0; m_cnt = 8'h00;
        m_pend_ext = 1'b0; m_pend_brk = 1'b0;
    endtask

    // Keyboard semantics: E0 qualifies the next code, F0 announces a release.
    task automatic model_byte(input logic [7:0] b);
        if (m_pend_brk) begin
            if (b == m_code && m_pend_ext == m_ext) m_held = 1'b0;
            m_pend_brk = 1'b0;
            m_pend_ext = 1'b0;
        end else if (b == 8'hE0 && !m_pend_ext) begin
            m_pend_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_pend_brk = 1'b1;
        end else begin
            if (!m_held || b != m_code || m_pend_ext != m_ext) m_cnt = m_cnt + 8'd1;
            m_code = b;
            m_ext = m_pend_ext;
            m_held = 1'b1;
            m_pend_ext = 1'b0;
        end
    endtask

    task automatic send_raw(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); ps2_data = f[i];
            repeat (3) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (3) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        send_raw(frame_of(b, bad), 11);
        repeat (8) @(posedge clk);
        if (!bad) model_byte(b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1;
        clrn = 1'b0;
        repeat (4) @(posedge clk);
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp_vec());
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_make_break();
        logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL make_break[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [4] = '{8'h1C, 8'h1C, 8'h1C, 8'h32};
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL typematic[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL extended[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_parity_error();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1);
        vectors++;
        if (err_pulses - e0 !== 1) begin
            miscompares++;
            $display("FAIL parity_err_pulses: got %0d expected 1", err_pulses - e0);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL parity_state: got %h expected %h", obs, exp_vec());
        end
        e0 = err_pulses;
        send_frame(8'h1C, 1'b0);
        vectors++;
        if (obs !== exp_vec() || err_pulses != e0) begin
            miscompares++;
            $display("FAIL parity_recover: got %h/%0d expected %h/0", obs, err_pulses - e0, exp_vec());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 1'b0);
            if (i == 127 || i == 255) begin
                vectors++;
                if (obs !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL wrap_press_%0d: got %h expected %h", i + 1, obs, exp_vec());
                end
            end
        end
        send_frame(8'h1C, 1'b0);
        vectors++;
        if ({cnt_hi, cnt_lo} !== 8'h01 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap_after: got %h expected cnt 01 vec %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h32, 1'b0);
        send_raw(frame_of(8'h1C, 1'b0), 5);
        @(posedge clk);
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL midframe_reset: got %h expected %h", obs, exp_vec());
        end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL midframe_next: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [4] = '{8'h1C, 8'h32, 8'h75, 8'h6B};
        logic [7:0] b;
        int         sel;
        int         e0;
        bit         bad;
        for (int i = 0; i < 100; i++) begin
            sel = int'($urandom_range(0, 9));
            bad = 1'b0;
            if (sel < 2)       b = 8'hE0;
            else if (sel < 4)  b = 8'hF0;
            else if (sel == 9) b = 8'($urandom);
            else               b = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) bad = 1'b1;
            e0 = err_pulses;
            send_frame(b, bad);
            vectors++;
            if (obs !== exp_vec() || (err_pulses - e0) != int'(bad)) begin
                miscompares++;
                $display("FAIL random[%0d] byte %h bad %0d: got %h err %0d expected %h err %0d",
                         i, b, bad, obs, err_pulses - e0, exp_vec(), bad);
            end
        end
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        send_raw(frame_of(8'h75, 1'b0), 4);
        repeat (c_tb_timeout + 20) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (err_pulses - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %0d expected 1", err_pulses - e0);
        end
        e0 = err_pulses;
        send_frame(8'h75, 1'b0);
        vectors++;
        if (obs !== exp_vec() || err_pulses != e0) begin
            miscompares++;
            $display("FAIL timeout_recover: got %h expected %h", obs, exp_vec());
        end
    endtask
`endif

    initial begin
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_parity_error();
        test_reset_midframe();
        test_random();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`endif
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
